// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared state encoding, line width and index/tag helpers for the data-cache fill controller
package dc_pkg;

  localparam int LINE_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VRD  = 3'd1,
    ST_WREQ = 3'd2,
    ST_FREQ = 3'd3,
    ST_FWR  = 3'd4,
    ST_FIN1 = 3'd5,
    ST_FIN2 = 3'd6
  } dc_state_e;

  // Line index is adr[dwidth+1:4]; returned zero-extended so callers size-cast to their index width.
  function automatic logic [31:0] line_idx(input logic [31:0] adr, input int dwidth);
    logic [31:0] mask;
    mask = (32'd1 << (dwidth - 2)) - 32'd1;
    return (adr >> 4) & mask;
  endfunction

  // Tag is adr[31:dwidth+2]; returned zero-extended.
  function automatic logic [31:0] line_tag(input logic [31:0] adr, input int dwidth);
    return adr >> (dwidth + 2);
  endfunction

endpackage

// File: rtl/dc_tag_ram.sv
// rtl/dc_tag_ram.sv - direct-mapped tag/valid/dirty array with async lookup and sync update
module dc_tag_ram
  import dc_pkg::*;
#(
  parameter int DWIDTH = 11,
  parameter int TWIDTH = 30 - DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-3:0] lk_idx_i,
  input  logic [TWIDTH-1:0] lk_tag_i,
  output logic              lk_hit_o,
  output logic              lk_dirty_o,
  output logic [TWIDTH-1:0] lk_vtag_o,
  input  logic              fill_en_i,
  input  logic              dirty_set_i
);

  localparam int NLINES = 1 << (DWIDTH - 2);

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TWIDTH-1:0] tag_q [NLINES];

  // Lookup is purely combinational so the hit answer lands in the same MA cycle.
  always_comb begin
    lk_vtag_o  = tag_q[lk_idx_i];
    lk_hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    lk_dirty_o = valid_q[lk_idx_i] && dirty_q[lk_idx_i];
  end

  // Valid/dirty are cleared by reset so an aborted miss leaves every line invalid; a fill wins over a dirty set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[lk_idx_i] <= 1'b1;
      dirty_q[lk_idx_i] <= 1'b0;
    end else if (dirty_set_i) begin
      dirty_q[lk_idx_i] <= 1'b1;
    end
  end

  // Tag storage needs no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[lk_idx_i] <= lk_tag_i;
    end
  end

endmodule

// File: rtl/dc_fill_ctrl.sv
// rtl/dc_fill_ctrl.sv - data-cache miss FSM, line buffer and memory interface; optional counters under DC_PERF_CNT_EN
module dc_fill_ctrl
  import dc_pkg::*;
#(
  parameter int DWIDTH = 11,
  parameter int TWIDTH = 30 - DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [31:0]       rd_data_ma,
  input  logic              dc_cache_wr_ma,
  output logic              dc_tag_hit_ma,
  output logic              dc_st_wt_ma,
  output logic              dc_miss_stall,
  output logic              dc_stall_fin2,
  output logic [DWIDTH-3:0] ram_radr_all,
  input  logic [LINE_W-1:0] ram_rdata_all,
  output logic              ram_ren_all,
  output logic [DWIDTH-3:0] ram_wadr_all,
  output logic [LINE_W-1:0] ram_wdata_all,
  output logic              ram_wen_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [27:0]       mem_adr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
`ifdef DC_PERF_CNT_EN
  output logic [31:0]       dc_hit_cnt,
  output logic [31:0]       dc_miss_cnt,
`endif
  input  logic              mem_ack
);

  localparam int IDX_W = DWIDTH - 2;

  dc_state_e         state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [IDX_W-1:0]  idx;
  logic [TWIDTH-1:0] adr_tag;
  logic              io;
  logic              req;
  logic              lk_hit;
  logic              lk_dirty;
  logic [TWIDTH-1:0] lk_vtag;
  logic              miss;
  logic              fill_en;
  logic              dirty_set;
  logic              miss_start;

  // MA is frozen during a stall, so index and tag come straight from the stage address.
  always_comb begin
    idx     = IDX_W'(line_idx(rd_data_ma, DWIDTH));
    adr_tag = TWIDTH'(line_tag(rd_data_ma, DWIDTH));
    io      = (rd_data_ma[31:30] == 2'b11);
    req     = cmd_ld_ma | cmd_st_ma;
    miss    = req & ~io & ~lk_hit;
  end

  dc_tag_ram #(
    .DWIDTH (DWIDTH),
    .TWIDTH (TWIDTH)
  ) u_tag_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_idx_i    (idx),
    .lk_tag_i    (adr_tag),
    .lk_hit_o    (lk_hit),
    .lk_dirty_o  (lk_dirty),
    .lk_vtag_o   (lk_vtag),
    .fill_en_i   (fill_en),
    .dirty_set_i (dirty_set)
  );

  // Hit/stall flags and the write-back-only store policy; IO space is always a hit and never marks a line dirty.
  always_comb begin
    dc_tag_hit_ma = io | lk_hit;
    dc_st_wt_ma   = 1'b0;
    dc_miss_stall = (state_q != ST_IDLE) | miss;
    dirty_set     = dc_cache_wr_ma & lk_hit & ~io;
    ram_wdata_all = line_q;
    mem_wdata     = line_q;
  end

  // State, pending-read flag and line buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_pend_q <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      line_q    <= line_d;
    end
  end

  // Next-state and per-state outputs; VRD spends one cycle issuing the read and one capturing the victim.
  always_comb begin
    state_d       = state_q;
    rd_pend_d     = rd_pend_q;
    line_d        = line_q;
    ram_ren_all   = 1'b0;
    ram_radr_all  = '0;
    ram_wen_all   = 1'b0;
    ram_wadr_all  = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_adr       = '0;
    dc_stall_fin2 = 1'b0;
    fill_en       = 1'b0;
    miss_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          miss_start = 1'b1;
          state_d    = lk_dirty ? ST_VRD : ST_FREQ;
        end
      end
      ST_VRD: begin
        if (!rd_pend_q) begin
          ram_ren_all  = 1'b1;
          ram_radr_all = idx;
          rd_pend_d    = 1'b1;
        end else begin
          line_d    = ram_rdata_all;
          rd_pend_d = 1'b0;
          state_d   = ST_WREQ;
        end
      end
      ST_WREQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_adr = {lk_vtag, idx};
        if (mem_ack) begin
          state_d = ST_FREQ;
        end
      end
      ST_FREQ: begin
        mem_req = 1'b1;
        mem_adr = rd_data_ma[31:4];
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = ST_FWR;
        end
      end
      ST_FWR: begin
        ram_wen_all  = 1'b1;
        ram_wadr_all = idx;
        fill_en      = 1'b1;
        state_d      = ST_FIN1;
      end
      ST_FIN1: begin
        state_d = ST_FIN2;
      end
      ST_FIN2: begin
        dc_stall_fin2 = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DC_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Hits count only in IDLE so a retried access after a fill is not double counted; both counters wrap.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == ST_IDLE) && req && !io && lk_hit) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_start) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign dc_hit_cnt  = hit_cnt_q;
  assign dc_miss_cnt = miss_cnt_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

endmodule

// File: tb/tb_dc_fill_ctrl.sv
// tb/tb_dc_fill_ctrl.sv - directed scoreboard bench for dc_fill_ctrl
module tb_dc_fill_ctrl;

  localparam int DWIDTH = 11;
  localparam int IW     = DWIDTH - 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_ld_ma, cmd_st_ma, dc_cache_wr_ma;
  logic [31:0]   rd_data_ma;
  logic          dc_tag_hit_ma, dc_st_wt_ma, dc_miss_stall, dc_stall_fin2;
  logic [IW-1:0] ram_radr_all, ram_wadr_all;
  logic [127:0]  ram_rdata_all, ram_wdata_all;
  logic          ram_ren_all, ram_wen_all;
  logic          mem_req, mem_we, mem_ack;
  logic [27:0]   mem_adr;
  logic [127:0]  mem_wdata, mem_rdata;
`ifdef DC_PERF_CNT_EN
  logic [31:0]   dc_hit_cnt, dc_miss_cnt;
`endif

  dc_fill_ctrl #(.DWIDTH(DWIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_ld_ma      (cmd_ld_ma),
    .cmd_st_ma      (cmd_st_ma),
    .rd_data_ma     (rd_data_ma),
    .dc_cache_wr_ma (dc_cache_wr_ma),
    .dc_tag_hit_ma  (dc_tag_hit_ma),
    .dc_st_wt_ma    (dc_st_wt_ma),
    .dc_miss_stall  (dc_miss_stall),
    .dc_stall_fin2  (dc_stall_fin2),
    .ram_radr_all   (ram_radr_all),
    .ram_rdata_all  (ram_rdata_all),
    .ram_ren_all    (ram_ren_all),
    .ram_wadr_all   (ram_wadr_all),
    .ram_wdata_all  (ram_wdata_all),
    .ram_wen_all    (ram_wen_all),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_adr        (mem_adr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
`ifdef DC_PERF_CNT_EN
    .dc_hit_cnt     (dc_hit_cnt),
    .dc_miss_cnt    (dc_miss_cnt),
`endif
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  // Line RAM model: registered read, one-cycle latency.
  logic [127:0] ram_m [0:(1<<IW)-1];
  always @(posedge clk) begin
    if (ram_wen_all) ram_m[ram_wadr_all] <= ram_wdata_all;
    if (ram_ren_all) ram_rdata_all <= ram_m[ram_radr_all];
  end

  typedef struct {
    logic         we;
    logic [27:0]  adr;
    logic [127:0] wdata;
  } mem_exp_t;

  mem_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LINE_B = 128'hA5A5_0000_1111_2222_3333_4444_5555_C3C3;
  localparam logic [127:0] LINE_C = 128'h0BAD_F00D_DEAD_BEEF_CAFE_0001_0002_0003;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until mem_req shows up; a missing request counts as a failure.
  task automatic wait_req(input string tag, output bit ren_seen);
    ren_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ram_ren_all) ren_seen = 1'b1;
      if (mem_req) break;
    end
    check({tag, "_req"}, mem_req, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    mem_exp_t e;
    check({tag, "_sb_avail"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_we"}, mem_we, e.we);
      check({tag, "_adr"}, mem_adr, e.adr);
      if (e.we) check({tag, "_wdata"}, mem_wdata, e.wdata);
    end
  endtask

  task automatic ack(input logic [127:0] d);
    mem_rdata = d;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  // Called at the negedge after the fetch ack: FWR, FIN1, FIN2, then back to IDLE.
  task automatic finish_fill(input string tag, input logic [127:0] line, input logic [IW-1:0] idx);
    check({tag, "_wen"}, ram_wen_all, 1'b1);
    check({tag, "_wdata"}, ram_wdata_all, line);
    check({tag, "_wadr"}, ram_wadr_all, idx);
    check({tag, "_stall_fwr"}, dc_miss_stall, 1'b1);
    @(negedge clk);
    check({tag, "_fin1_hit"}, dc_tag_hit_ma, 1'b1);
    check({tag, "_fin1_nopulse"}, dc_stall_fin2, 1'b0);
    @(negedge clk);
    check({tag, "_fin2"}, dc_stall_fin2, 1'b1);
    check({tag, "_fin2_stall"}, dc_miss_stall, 1'b1);
    cmd_ld_ma = 1'b0;
    cmd_st_ma = 1'b0;
    dc_cache_wr_ma = 1'b0;
    @(negedge clk);
    check({tag, "_stall_drop"}, dc_miss_stall, 1'b0);
    check({tag, "_fin2_drop"}, dc_stall_fin2, 1'b0);
  endtask

  bit ren_seen;

  initial begin
    rst_n = 1'b0; cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; dc_cache_wr_ma = 1'b0;
    rd_data_ma = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_stall", dc_miss_stall, 1'b0);
    check("rst_fin2", dc_stall_fin2, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_adr", mem_adr, 28'h0);
    check("rst_ren", ram_ren_all, 1'b0);
    check("rst_wen", ram_wen_all, 1'b0);
    check("rst_hit", dc_tag_hit_ma, 1'b0);
    check("rst_stwt", dc_st_wt_ma, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean miss on 0x40
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_0040;
    exp_q.push_back('{we: 1'b0, adr: 28'h000_0004, wdata: '0});
    #1;
    check("s1_hit", dc_tag_hit_ma, 1'b0);
    check("s1_stall", dc_miss_stall, 1'b1);
    wait_req("s1", ren_seen);
    check("s1_no_vrd", ren_seen, 1'b0);
    pop_check("s1_fetch");
    ack(LINE_A);
    finish_fill("s1", LINE_A, 9'd4);

    // 2: hit on 0x40, then a stray ack in IDLE
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_0040;
    #1;
    check("s2_hit", dc_tag_hit_ma, 1'b1);
    check("s2_stall", dc_miss_stall, 1'b0);
    @(negedge clk);
    check("s2_noreq", mem_req, 1'b0);
    cmd_ld_ma = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("s2_ack_ign_stall", dc_miss_stall, 1'b0);
    check("s2_ack_ign_req", mem_req, 1'b0);
`ifdef DC_PERF_CNT_EN
    check("s6_miss_cnt", dc_miss_cnt, 32'd1);
    check("s6_hit_cnt", dc_hit_cnt, 32'd1);
    dut.hit_cnt_q = 32'hFFFF_FFFF;
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_0040;
    @(negedge clk);
    cmd_ld_ma = 1'b0;
    check("s6_hit_wrap", dc_hit_cnt, 32'd0);
`endif

    // 3: store hit marks dirty, conflicting load evicts it
    cmd_st_ma = 1'b1; dc_cache_wr_ma = 1'b1; rd_data_ma = 32'h0000_0040;
    #1;
    check("s3_st_hit", dc_tag_hit_ma, 1'b1);
    check("s3_st_stall", dc_miss_stall, 1'b0);
    @(negedge clk);
    cmd_st_ma = 1'b0; dc_cache_wr_ma = 1'b0;
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_0040 + (32'd1 << (DWIDTH + 2));
    exp_q.push_back('{we: 1'b1, adr: 28'h000_0004, wdata: LINE_A});
    exp_q.push_back('{we: 1'b0, adr: 28'h000_0204, wdata: '0});
    #1;
    check("s3_ld_hit", dc_tag_hit_ma, 1'b0);
    check("s3_ld_stall", dc_miss_stall, 1'b1);
    wait_req("s3_wb", ren_seen);
    check("s3_vrd", ren_seen, 1'b1);
    pop_check("s3_wb");
    ack(LINE_C);
    wait_req("s3_fetch", ren_seen);
    pop_check("s3_fetch");
    ack(LINE_B);
    finish_fill("s3", LINE_B, 9'd4);

    // 4: IO access always hits and leaves tags alone
    cmd_ld_ma = 1'b1; rd_data_ma = 32'hC000_0010;
    #1;
    check("s4_io_hit", dc_tag_hit_ma, 1'b1);
    check("s4_io_stall", dc_miss_stall, 1'b0);
    @(negedge clk);
    cmd_ld_ma = 1'b0; rd_data_ma = 32'h0000_0010;
    #1;
    check("s4_idx1_invalid", dc_tag_hit_ma, 1'b0);
    rd_data_ma = 32'h0000_0040 + (32'd1 << (DWIDTH + 2));
    #1;
    check("s4_idx4_kept", dc_tag_hit_ma, 1'b1);
    @(negedge clk);

    // 5: long fetch wait, then reset mid-miss
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_3000;
    exp_q.push_back('{we: 1'b0, adr: 28'h000_0300, wdata: '0});
    wait_req("s5", ren_seen);
    pop_check("s5_fetch");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("s5_hold_req", mem_req, 1'b1);
      check("s5_hold_adr", mem_adr, 28'h000_0300);
      check("s5_hold_stall", dc_miss_stall, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("s5_rst_req", mem_req, 1'b0);
    check("s5_rst_fin2", dc_stall_fin2, 1'b0);
    cmd_ld_ma = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h0000_0040;
    #1;
    check("s5_relookup_hit", dc_tag_hit_ma, 1'b0);
    check("s5_relookup_stall", dc_miss_stall, 1'b1);
    cmd_ld_ma = 1'b0;
    check("s5_sb_empty", exp_q.size(), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
